cpu_param: RTL and testbench

- Parametrised single-cycle CPU core and the successor to the fixed 8-bit, 8-register core.
- Data width, register count and PC width are parameters.
- Adds instructions the previous core lacks: unconditional jump, branch-if-equal and halt, with a two-state run/halt FSM.
- Sits between the instruction memory (fetch by PC, combinational return) and a testbench debug read port; there is no data memory in this generation.

---
 rtl/cpu_param_pkg.sv | 33 +++
 rtl/cpu_param_regfile.sv | 36 +++
 rtl/cpu_param.sv | 115 +++++++++++
 tb/tb_cpu_param.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cpu_param_pkg.sv
// Shared encodings for the parametrised single-cycle core: opcodes, ALU selects,
// run/halt states and instruction field positions.
package cpu_param_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_HALT  = 8'd8;

  typedef enum logic [2:0] {
    ALU_FWD,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_sel_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;

endpackage

// File: rtl/cpu_param_regfile.sv
// NREG x DATA_W register file: two combinational read ports, a debug read port,
// one synchronous write port and a synchronous clear.
module cpu_param_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
  assign rdata1_o   = regs_q[raddr1_i];
  assign rdata2_o   = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/cpu_param.sv
// Parametrised single-cycle core with jump, branch-if-equal and a run/halt FSM.
// Instructions arrive combinationally from imem at the registered PC.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned PC_W   = 10
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic [PC_W-1:0]         PC,
  input  logic [31:0]             INSTRUCTION,
  output logic                    HALTED,
  output logic                    ILLEGAL,
  input  logic [$clog2(NREG)-1:0] DBG_ADDR,
  output logic [DATA_W-1:0]       DBG_DATA
);

  localparam int unsigned AW = $clog2(NREG);

  logic [PC_W-1:0]   pc_q, pc_plus4, offset, pc_next;
  state_e            state_q;
  logic              halted_q;
  logic [7:0]        opcode;
  logic [AW-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm, fwd_val, alu_y;
  alu_sel_e          alu_sel;
  logic              dec_we, legal, is_j, is_beq, is_halt, run, take;
  logic              unused_src1_hi;

  assign opcode = INSTRUCTION[OPC_LSB +: 8];
  assign rd     = INSTRUCTION[DST_LSB +: AW];
  assign rs1    = INSTRUCTION[SRC1_LSB +: AW];
  assign rs2    = INSTRUCTION[SRC2_LSB +: AW];
  assign imm    = DATA_W'(INSTRUCTION[SRC2_LSB +: 8]);
  assign unused_src1_hi = ^INSTRUCTION[SRC1_LSB+7 : SRC1_LSB+AW];
  assign run    = (state_q == ST_RUN);

  always_comb begin
    dec_we  = 1'b0;
    alu_sel = ALU_FWD;
    fwd_val = rs2_val;
    legal   = 1'b1;
    is_j    = 1'b0;
    is_beq  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_LOADI: begin dec_we = 1'b1; fwd_val = imm; end
      OP_MOV:   dec_we = 1'b1;
      OP_ADD:   begin dec_we = 1'b1; alu_sel = ALU_ADD; end
      OP_SUB:   begin dec_we = 1'b1; alu_sel = ALU_SUB; end
      OP_AND:   begin dec_we = 1'b1; alu_sel = ALU_AND; end
      OP_OR:    begin dec_we = 1'b1; alu_sel = ALU_OR; end
      OP_J:     is_j = 1'b1;
      OP_BEQ:   is_beq = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_y = fwd_val;
    case (alu_sel)
      ALU_ADD: alu_y = rs1_val + rs2_val;
      ALU_SUB: alu_y = rs1_val + ~rs2_val + DATA_W'(1);
      ALU_AND: alu_y = rs1_val & rs2_val;
      ALU_OR:  alu_y = rs1_val | rs2_val;
      default: alu_y = fwd_val;
    endcase
  end

  // Word offset sign-extended into byte units; all PC arithmetic wraps at 2^PC_W.
  assign offset   = PC_W'($signed({INSTRUCTION[DST_LSB +: 8], 2'b00}));
  assign pc_plus4 = pc_q + PC_W'(4);
  assign take     = is_j | (is_beq & (rs1_val == rs2_val));
  assign pc_next  = take ? (pc_plus4 + offset) : pc_plus4;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q     <= '0;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (is_halt) begin
        state_q  <= ST_HALT;
        halted_q <= 1'b1;
      end else begin
        pc_q <= pc_next;
      end
    end
  end

  cpu_param_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .we_i       (dec_we & run),
    .waddr_i    (rd),
    .wdata_i    (alu_y),
    .raddr1_i   (rs1),
    .rdata1_o   (rs1_val),
    .raddr2_i   (rs2),
    .rdata2_o   (rs2_val),
    .dbg_addr_i (DBG_ADDR),
    .dbg_data_o (DBG_DATA)
  );

  assign PC      = pc_q;
  assign HALTED  = halted_q;
  assign ILLEGAL = run & ~legal;

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: default 8-bit core driven from a vector table
// through a scoreboard queue, plus a 16-bit/16-register instance.
module tb_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, halted8, ill8;
  logic [31:0] ins8 = '0;
  logic [9:0]  pc8;
  logic [2:0]  da8 = '0;
  logic [7:0]  dd8;

  logic        rst16 = 1'b1, halted16, ill16;
  logic [31:0] ins16 = '0;
  logic [9:0]  pc16;
  logic [3:0]  da16 = '0;
  logic [15:0] dd16;

  cpu_param dut (
    .CLK(clk), .RESET(rst8), .PC(pc8), .INSTRUCTION(ins8), .HALTED(halted8),
    .ILLEGAL(ill8), .DBG_ADDR(da8), .DBG_DATA(dd8)
  );

  cpu_param #(.DATA_W(16), .NREG(16), .PC_W(10)) dut16 (
    .CLK(clk), .RESET(rst16), .PC(pc16), .INSTRUCTION(ins16), .HALTED(halted16),
    .ILLEGAL(ill16), .DBG_ADDR(da16), .DBG_DATA(dd16)
  );

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [2:0]  da;
    logic [9:0]  pc;
    logic [7:0]  dd;
    logic        ill;
    logic        hlt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, d, s1, s2);
    return {op, d, s1, s2};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [31:0] i, input logic [2:0] da,
                              input logic [9:0] pc, input logic [7:0] dd,
                              input logic ill, input logic hlt);
    vec_t v;
    v.rst = rst; v.ins = i; v.da = da; v.pc = pc; v.dd = dd; v.ill = ill; v.hlt = hlt;
    return v;
  endfunction

  task automatic apply(input string nm, input vec_t v);
    vec_t e;
    @(negedge clk);
    rst8 = v.rst; ins8 = v.ins; da8 = v.da;
    #1;
    chk({nm, " ILLEGAL"}, 32'(ill8), 32'(v.ill));
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, " PC"}, 32'(pc8), 32'(e.pc));
    chk({nm, " HALTED"}, 32'(halted8), 32'(e.hlt));
    chk({nm, " DBG"}, 32'(dd8), 32'(e.dd));
  endtask

  task automatic step16(input string nm, input logic rst, input logic [31:0] i,
                        input logic [3:0] da, input logic [15:0] exp);
    @(negedge clk);
    rst16 = rst; ins16 = i; da16 = da;
    @(posedge clk);
    #1;
    chk(nm, 32'(dd16), 32'(exp));
  endtask

  initial begin
    tbl[0]  = mk(1, ins(8'h00, 8'h00, 8'h00, 8'h00), 3'd0, 10'd0,  8'h00, 0, 0);
    tbl[1]  = mk(0, ins(8'h00, 8'h01, 8'h00, 8'h02), 3'd1, 10'd4,  8'h02, 0, 0);
    tbl[2]  = mk(0, ins(8'h00, 8'h02, 8'h00, 8'h03), 3'd2, 10'd8,  8'h03, 0, 0);
    tbl[3]  = mk(0, ins(8'h02, 8'h05, 8'h01, 8'h02), 3'd5, 10'd12, 8'h05, 0, 0);
    tbl[4]  = mk(0, ins(8'h03, 8'h04, 8'h01, 8'h02), 3'd4, 10'd16, 8'hFF, 0, 0);
    tbl[5]  = mk(0, ins(8'h04, 8'h06, 8'h01, 8'h02), 3'd6, 10'd20, 8'h02, 0, 0);
    tbl[6]  = mk(0, ins(8'h07, 8'hFE, 8'h01, 8'h01), 3'd5, 10'd16, 8'h05, 0, 0);
    tbl[7]  = mk(0, ins(8'h05, 8'h03, 8'h01, 8'h02), 3'd3, 10'd20, 8'h03, 0, 0);
    tbl[8]  = mk(0, ins(8'h07, 8'hFE, 8'h01, 8'h02), 3'd3, 10'd24, 8'h03, 0, 0);
    tbl[9]  = mk(0, ins(8'h06, 8'h03, 8'h00, 8'h00), 3'd3, 10'd40, 8'h03, 0, 0);
    tbl[10] = mk(0, ins(8'h01, 8'h07, 8'h00, 8'h02), 3'd7, 10'd44, 8'h03, 0, 0);
    tbl[11] = mk(0, ins(8'h2A, 8'h01, 8'h01, 8'h02), 3'd1, 10'd48, 8'h02, 1, 0);
    tbl[12] = mk(0, ins(8'h00, 8'h08, 8'h00, 8'hAB), 3'd0, 10'd52, 8'hAB, 0, 0);
    tbl[13] = mk(0, ins(8'h02, 8'h01, 8'h01, 8'h01), 3'd1, 10'd56, 8'h04, 0, 0);
    tbl[14] = mk(0, ins(8'h09, 8'h01, 8'h01, 8'h01), 3'd1, 10'd60, 8'h04, 1, 0);
    tbl[15] = mk(0, ins(8'h08, 8'h00, 8'h00, 8'h00), 3'd1, 10'd60, 8'h04, 0, 1);

    for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Halted: PC frozen, writes and illegal flag suppressed.
    for (int i = 0; i < 5; i++)
      apply($sformatf("halt_hold%0d", i), mk(0, ins(8'h00, 8'h01, 8'h00, 8'h77), 3'd1, 10'd60, 8'h04, 0, 1));
    apply("halt_illegal", mk(0, ins(8'h2A, 8'h01, 8'h01, 8'h02), 3'd1, 10'd60, 8'h04, 0, 1));

    // Reset wins over a halt instruction presented in the same cycle.
    apply("reset_over_halt", mk(1, ins(8'h08, 8'h00, 8'h00, 8'h00), 3'd1, 10'd0, 8'h00, 0, 0));
    for (int r = 0; r < 8; r++) begin
      da8 = 3'(r);
      #1;
      chk($sformatf("reg%0d_cleared", r), 32'(dd8), 32'h0);
    end

    apply("post_reset_loadi", mk(0, ins(8'h00, 8'h03, 8'h00, 8'h05), 3'd3, 10'd4, 8'h05, 0, 0));
    apply("reset_discard",    mk(1, ins(8'h00, 8'h03, 8'h00, 8'h07), 3'd3, 10'd0, 8'h00, 0, 0));
    apply("j_minus1_at0",     mk(0, ins(8'h06, 8'hFF, 8'h00, 8'h00), 3'd3, 10'd0, 8'h00, 0, 0));
    apply("j_to_3fc",         mk(0, ins(8'h06, 8'hFE, 8'h00, 8'h00), 3'd3, 10'h3FC, 8'h00, 0, 0));
    apply("pc_wrap",          mk(0, ins(8'h02, 8'h05, 8'h01, 8'h02), 3'd5, 10'd0, 8'h00, 0, 0));

    // Wide instance: 16-bit wrap and the top register.
    step16("w16_reset",   1, ins(8'h00, 8'h00, 8'h00, 8'h00), 4'd15, 16'h0000);
    step16("w16_loadi",   0, ins(8'h00, 8'h1F, 8'h00, 8'hFF), 4'd15, 16'h00FF);
    step16("w16_one",     0, ins(8'h00, 8'h0E, 8'h00, 8'h01), 4'd14, 16'h0001);
    step16("w16_sub",     0, ins(8'h03, 8'h0D, 8'h00, 8'h0E), 4'd13, 16'hFFFF);
    step16("w16_wrap",    0, ins(8'h02, 8'h0F, 8'h0D, 8'h0E), 4'd15, 16'h0000);
    step16("w16_r15",     0, ins(8'h02, 8'h0F, 8'h0D, 8'h00), 4'd15, 16'hFFFF);
    chk("w16_pc", 32'(pc16), 32'd20);
    chk("w16_halted", 32'(halted16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
